// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM command sequencer and its refresh timer.
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        S_INIT_REQ  = 3'd0,
        S_INIT_WAIT = 3'd1,
        S_IDLE      = 3'd2,
        S_GRANT     = 3'd3,
        S_WAIT      = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    localparam logic [1:0] SUB_INIT = 2'd0;
    localparam logic [1:0] SUB_REF  = 2'd1;
    localparam logic [1:0] SUB_WR   = 2'd2;
    localparam logic [1:0] SUB_RD   = 2'd3;

    // Client address packing: {bank, row, col}
    localparam int BANK_HI = 24;
    localparam int BANK_LO = 23;
    localparam int ROW_HI  = 22;
    localparam int ROW_LO  = 10;
    localparam int COL_HI  = 9;
    localparam int COL_LO  = 0;

    function automatic logic [3:0] sub_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh timer: free-runs once started and raises a sticky pending flag on expiry.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 390
) (
    input  logic iclk,
    input  logic ireset_n,
    input  logic istart,
    input  logic iclear,
    output logic oref_pending
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          w_expire;

    assign w_expire     = r_run && (r_cnt == CW'(REF_PERIOD - 1));
    assign oref_pending = r_pending;

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            r_run     <= 1'b0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (istart) begin
                r_run <= 1'b1;
                r_cnt <= '0;
            end else if (r_run) begin
                r_cnt <= w_expire ? '0 : r_cnt + 1'b1;
            end
            // A fresh expiry must survive a same-cycle clear from the refresh grant.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (iclear) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_sched.sv
// SDRAM top-level sequencer: runs init once, then grants the command bus to refresh,
// write or read sub-FSMs one at a time with a turnaround gap between grants.
module sdram_sched
    import sdram_sched_pkg::*;
#(
    parameter int REF_PERIOD = 390,
    parameter int TIMEOUT    = 255
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        iwr_req,
    input  logic [24:0] iwr_addr,
    input  logic [15:0] iwr_data,
    output logic        owr_ack,
    input  logic        ird_req,
    input  logic [24:0] ird_addr,
    output logic        ord_ack,
    output logic        odone,
    output logic [3:0]  osub_req,
    output logic [3:0]  osub_enb,
    input  logic [3:0]  isub_fin,
    output logic [12:0] orow,
    output logic [9:0]  ocolumn,
    output logic [1:0]  obank,
    output logic [15:0] odata,
    output logic        oready,
    output logic        oerr,
    output logic [2:0]  odbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_idx;
    logic [1:0]    w_next_idx;
    logic [TW-1:0] r_wait_cnt;
    logic          r_started;
    logic          r_done;
    logic          r_ready;
    logic          r_err;
    logic [12:0]   r_row;
    logic [9:0]    r_col;
    logic [1:0]    r_bank;
    logic [15:0]   r_data;
    logic          w_ref_pending;
    logic          w_fin;
    logic          w_tmo;
    logic          w_init_fin;

    assign w_fin      = isub_fin[r_idx];
    assign w_tmo      = (r_wait_cnt == TW'(TIMEOUT - 1));
    assign w_init_fin = (r_state == S_INIT_WAIT) && isub_fin[SUB_INIT];

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
        .iclk         (iclk),
        .ireset_n     (ireset_n),
        .istart       (w_init_fin),
        .iclear       ((r_state == S_GRANT) && (r_idx == SUB_REF)),
        .oref_pending (w_ref_pending)
    );

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            r_state <= S_INIT_REQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        case (r_state)
            // Hold off one cycle after reset so the init request is seen outside reset.
            S_INIT_REQ:  if (r_started) w_next = S_INIT_WAIT;
            S_INIT_WAIT: if (isub_fin[SUB_INIT]) w_next = S_GAP;
            S_IDLE: begin
                if (w_ref_pending) begin
                    w_next     = S_GRANT;
                    w_next_idx = SUB_REF;
                end else if (iwr_req) begin
                    w_next     = S_GRANT;
                    w_next_idx = SUB_WR;
                end else if (ird_req) begin
                    w_next     = S_GRANT;
                    w_next_idx = SUB_RD;
                end
            end
            S_GRANT:     w_next = S_WAIT;
            S_WAIT:      if (w_fin || w_tmo) w_next = S_GAP;
            S_GAP:       w_next = S_IDLE;
            default:     w_next = S_INIT_REQ;
        endcase
    end

    always_comb begin
        osub_req = 4'b0000;
        osub_enb = 4'b0000;
        owr_ack  = 1'b0;
        ord_ack  = 1'b0;
        case (r_state)
            S_INIT_REQ: begin
                if (r_started) begin
                    osub_req = sub_onehot(SUB_INIT);
                    osub_enb = sub_onehot(SUB_INIT);
                end
            end
            S_INIT_WAIT: osub_enb = sub_onehot(SUB_INIT);
            S_GRANT: begin
                osub_req = sub_onehot(r_idx);
                osub_enb = sub_onehot(r_idx);
                owr_ack  = (r_idx == SUB_WR);
                ord_ack  = (r_idx == SUB_RD);
            end
            S_WAIT:      osub_enb = sub_onehot(r_idx);
            default:     ;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            r_started  <= 1'b0;
            r_idx      <= SUB_INIT;
            r_wait_cnt <= '0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_bank     <= '0;
            r_data     <= '0;
        end else begin
            r_started <= 1'b1;
            r_done    <= 1'b0;
            r_idx     <= w_next_idx;
            case (r_state)
                S_INIT_WAIT: if (isub_fin[SUB_INIT]) r_ready <= 1'b1;
                S_GRANT: begin
                    r_wait_cnt <= '0;
                    if (r_idx == SUB_WR) begin
                        r_bank <= iwr_addr[BANK_HI:BANK_LO];
                        r_row  <= iwr_addr[ROW_HI:ROW_LO];
                        r_col  <= iwr_addr[COL_HI:COL_LO];
                        r_data <= iwr_data;
                    end else if (r_idx == SUB_RD) begin
                        r_bank <= ird_addr[BANK_HI:BANK_LO];
                        r_row  <= ird_addr[ROW_HI:ROW_LO];
                        r_col  <= ird_addr[COL_HI:COL_LO];
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_fin) begin
                        r_done <= (r_idx == SUB_WR) || (r_idx == SUB_RD);
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign odone      = r_done;
    assign oready     = r_ready;
    assign oerr       = r_err;
    assign orow       = r_row;
    assign ocolumn    = r_col;
    assign obank      = r_bank;
    assign odata      = r_data;
    assign odbg_state = r_state;

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched with a short refresh period and timeout.
module tb_sdram_sched;

    localparam int REF_P = 20;
    localparam int TMO   = 35;

    localparam logic [2:0] ST_INIT_REQ  = 3'd0;
    localparam logic [2:0] ST_INIT_WAIT = 3'd1;
    localparam logic [2:0] ST_IDLE      = 3'd2;
    localparam logic [2:0] ST_WAIT      = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    logic        iclk;
    logic        ireset_n;
    logic        iwr_req;
    logic [24:0] iwr_addr;
    logic [15:0] iwr_data;
    logic        owr_ack;
    logic        ird_req;
    logic [24:0] ird_addr;
    logic        ord_ack;
    logic        odone;
    logic [3:0]  osub_req;
    logic [3:0]  osub_enb;
    logic [3:0]  isub_fin;
    logic [12:0] orow;
    logic [9:0]  ocolumn;
    logic [1:0]  obank;
    logic [15:0] odata;
    logic        oready;
    logic        oerr;
    logic [2:0]  odbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_sched #(.REF_PERIOD(REF_P), .TIMEOUT(TMO)) u_dut (
        .iclk       (iclk),
        .ireset_n   (ireset_n),
        .iwr_req    (iwr_req),
        .iwr_addr   (iwr_addr),
        .iwr_data   (iwr_data),
        .owr_ack    (owr_ack),
        .ird_req    (ird_req),
        .ird_addr   (ird_addr),
        .ord_ack    (ord_ack),
        .odone      (odone),
        .osub_req   (osub_req),
        .osub_enb   (osub_enb),
        .isub_fin   (isub_fin),
        .orow       (orow),
        .ocolumn    (ocolumn),
        .obank      (obank),
        .odata      (odata),
        .oready     (oready),
        .oerr       (oerr),
        .odbg_state (odbg_state)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int cnt;
        ireset_n = 1'b0;
        iwr_req  = 1'b0;
        ird_req  = 1'b0;
        iwr_addr = '0;
        iwr_data = '0;
        ird_addr = '0;
        isub_fin = 4'b0000;
        repeat (3) step();
        chk("rst_state", 32'(odbg_state), 32'(ST_INIT_REQ));
        chk("rst_req", 32'(osub_req), 32'h0);
        chk("rst_enb", 32'(osub_enb), 32'h0);
        chk("rst_ready", 32'(oready), 32'h0);
        chk("rst_err", 32'(oerr), 32'h0);
        chk("rst_latch", {obank, orow, ocolumn}, 32'h0);
        chk("rst_data", 32'(odata), 32'h0);
        chk("rst_pulses", {owr_ack, ord_ack, odone}, 32'h0);

        // Init handshake
        ireset_n = 1'b1;
        step();
        chk("init_req", 32'(osub_req), 32'h1);
        chk("init_enb", 32'(osub_enb), 32'h1);
        step();
        chk("init_wait_state", 32'(odbg_state), 32'(ST_INIT_WAIT));
        chk("init_req_pulse", 32'(osub_req), 32'h0);
        chk("init_wait_enb", 32'(osub_enb), 32'h1);
        iwr_req  = 1'b1;
        iwr_addr = {2'd1, 13'h0ABC, 10'h055};
        iwr_data = 16'hBEEF;
        repeat (7) step();
        chk("init_no_ack", 32'(owr_ack), 32'h0);
        chk("init_not_ready", 32'(oready), 32'h0);
        isub_fin = 4'b0001;
        step();
        isub_fin = 4'b0000;
        chk("init_ready", 32'(oready), 32'h1);
        chk("init_gap", 32'(odbg_state), 32'(ST_GAP));
        chk("init_gap_enb", 32'(osub_enb), 32'h0);
        chk("init_gap_ack", 32'(owr_ack), 32'h0);
        step();
        chk("init_idle", 32'(odbg_state), 32'(ST_IDLE));

        // Single write
        step();
        chk("wr_ack", 32'(owr_ack), 32'h1);
        chk("wr_req", 32'(osub_req), 32'h4);
        chk("wr_grant_enb", 32'(osub_enb), 32'h4);
        chk("wr_no_rd_ack", 32'(ord_ack), 32'h0);
        iwr_req = 1'b0;
        step();
        chk("wr_bank", 32'(obank), 32'h1);
        chk("wr_row", 32'(orow), 32'h0ABC);
        chk("wr_col", 32'(ocolumn), 32'h055);
        chk("wr_data", 32'(odata), 32'hBEEF);
        chk("wr_ack_pulse", 32'(owr_ack), 32'h0);
        chk("wr_wait_enb", 32'(osub_enb), 32'h4);
        isub_fin = 4'b1010;
        step();
        chk("wr_foreign_fin", 32'(odbg_state), 32'(ST_WAIT));
        chk("wr_foreign_done", 32'(odone), 32'h0);
        isub_fin = 4'b0100;
        step();
        isub_fin = 4'b0000;
        chk("wr_done", 32'(odone), 32'h1);
        chk("wr_gap_enb", 32'(osub_enb), 32'h0);
        step();
        chk("wr_done_pulse", 32'(odone), 32'h0);
        chk("wr_row_held", 32'(orow), 32'h0ABC);

        // Contention: refresh pending when both clients arrive
        repeat (14) step();
        chk("cont_idle", 32'(odbg_state), 32'(ST_IDLE));
        iwr_req  = 1'b1;
        iwr_addr = {2'd2, 13'h1555, 10'h3FF};
        iwr_data = 16'h1234;
        ird_req  = 1'b1;
        ird_addr = {2'd3, 13'h0F0F, 10'h2AA};
        step();
        chk("cont_ref_req", 32'(osub_req), 32'h2);
        chk("cont_ref_enb", 32'(osub_enb), 32'h2);
        chk("cont_ref_acks", {owr_ack, ord_ack}, 32'h0);
        step();
        isub_fin = 4'b0010;
        step();
        isub_fin = 4'b0000;
        chk("cont_ref_nodone", 32'(odone), 32'h0);
        chk("cont_ref_gap", 32'(odbg_state), 32'(ST_GAP));
        repeat (2) step();
        chk("cont_wr_ack", 32'(owr_ack), 32'h1);
        chk("cont_wr_req", 32'(osub_req), 32'h4);
        chk("cont_wr_no_rd", 32'(ord_ack), 32'h0);
        iwr_req = 1'b0;
        step();
        chk("cont_wr_data", 32'(odata), 32'h1234);
        chk("cont_wr_bank", 32'(obank), 32'h2);
        isub_fin = 4'b0100;
        step();
        isub_fin = 4'b0000;
        chk("cont_wr_done", 32'(odone), 32'h1);
        repeat (2) step();
        chk("cont_rd_ack", 32'(ord_ack), 32'h1);
        chk("cont_rd_req", 32'(osub_req), 32'h8);
        chk("cont_rd_no_wr", 32'(owr_ack), 32'h0);
        ird_req = 1'b0;
        step();
        chk("rd_bank", 32'(obank), 32'h3);
        chk("rd_row", 32'(orow), 32'h0F0F);
        chk("rd_col", 32'(ocolumn), 32'h2AA);
        chk("rd_data_kept", 32'(odata), 32'h1234);
        chk("rd_enb", 32'(osub_enb), 32'h8);
        chk("rd_err_before", 32'(oerr), 32'h0);

        // Read never finishes: timeout, with two refresh expiries during it
        n   = 0;
        cnt = 0;
        while (odbg_state == ST_WAIT && n < 200) begin
            step();
            n++;
            if (odone) cnt++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_no_done", 32'(cnt), 32'h0);
        chk("tmo_err", 32'(oerr), 32'h1);
        chk("tmo_gap", 32'(odbg_state), 32'(ST_GAP));
        chk("tmo_gap_enb", 32'(osub_enb), 32'h0);
        step();
        chk("tmo_idle", 32'(odbg_state), 32'(ST_IDLE));
        step();
        chk("tmo_ref_req", 32'(osub_req), 32'h2);
        step();
        isub_fin = 4'b0010;
        step();
        isub_fin = 4'b0000;
        step();
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (osub_req != 4'b0000) cnt++;
        end
        chk("ref_no_stack", 32'(cnt), 32'h0);

        // Write after timeout; refresh expiring meanwhile waits for it
        iwr_req  = 1'b1;
        iwr_addr = {2'd0, 13'h0001, 10'h001};
        iwr_data = 16'hA5A5;
        step();
        chk("post_wr_ack", 32'(owr_ack), 32'h1);
        chk("post_wr_req", 32'(osub_req), 32'h4);
        iwr_req = 1'b0;
        step();
        chk("post_wr_data", 32'(odata), 32'hA5A5);
        chk("post_wr_enb", 32'(osub_enb), 32'h4);
        isub_fin = 4'b0100;
        step();
        isub_fin = 4'b0000;
        chk("post_wr_done", 32'(odone), 32'h1);
        chk("err_sticky", 32'(oerr), 32'h1);
        repeat (2) step();
        chk("deferred_ref", 32'(osub_req), 32'h2);
        step();
        isub_fin = 4'b0010;
        step();
        isub_fin = 4'b0000;
        step();
        chk("pre_rst_idle", 32'(odbg_state), 32'(ST_IDLE));

        // Reset in the middle of a write
        iwr_req  = 1'b1;
        iwr_addr = {2'd1, 13'h0ABC, 10'h055};
        iwr_data = 16'hBEEF;
        step();
        chk("mid_wr_ack", 32'(owr_ack), 32'h1);
        iwr_req = 1'b0;
        step();
        chk("mid_wr_enb", 32'(osub_enb), 32'h4);
        ireset_n = 1'b0;
        step();
        chk("mid_rst_enb", 32'(osub_enb), 32'h0);
        chk("mid_rst_req", 32'(osub_req), 32'h0);
        chk("mid_rst_ready", 32'(oready), 32'h0);
        chk("mid_rst_err", 32'(oerr), 32'h0);
        chk("mid_rst_done", 32'(odone), 32'h0);
        chk("mid_rst_state", 32'(odbg_state), 32'(ST_INIT_REQ));
        chk("mid_rst_latch", {obank, orow, ocolumn}, 32'h0);
        ireset_n = 1'b1;
        step();
        chk("reinit_req", 32'(osub_req), 32'h1);
        step();
        chk("reinit_wait", 32'(odbg_state), 32'(ST_INIT_WAIT));
        chk("reinit_enb", 32'(osub_enb), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_sched.md
Name: sdram_sched

Overview:
- Top-level sequencer for the SDRAM sub-FSMs: init, auto-refresh, write and read.
- Runs init once after reset, then arbitrates between a periodic refresh timer and one write and one read client.
- Gives exactly one sub-FSM its req/enb pair at a time, so only one module drives the DRAM command bus.
- Latches client address and data and forwards them to the granted sub-FSM.

Parameters:
REF_PERIOD, 390, cycles between refresh requests (7.8 us at 50 MHz)
TIMEOUT, 255, maximum cycles a granted sub-FSM may run before it is aborted

Ports:
iclk  in  1  system clock; all logic on rising edge
ireset_n  in  1  synchronous active-low reset
iwr_req  in  1  write request; held until owr_ack
iwr_addr  in  25  {bank[24:23], row[22:10], col[9:0]}
iwr_data  in  16  write data
owr_ack  out  1  1-cycle pulse; write accepted, addr/data latched
ird_req  in  1  read request; held until ord_ack
ird_addr  in  25  same packing as iwr_addr
ord_ack  out  1  1-cycle pulse; read accepted
odone  out  1  1-cycle pulse; accepted client operation finished
osub_req  out  4  one-hot request pulse to sub-FSM, indexed INIT=0 REF=1 WR=2 RD=3
osub_enb  out  4  one-hot bus enable to sub-FSM
isub_fin  in  4  finish flags from sub-FSMs, same indexing
orow  out  13  latched row to sub-FSMs
ocolumn  out  10  latched column
obank  out  2  latched bank
odata  out  16  latched write data
oready  out  1  high once init has finished
oerr  out  1  sticky timeout flag

Behaviour:
- One clock (iclk); reset is synchronous and active-low (ireset_n).
- Reset values:
  - state = S_INIT_REQ.
  - All pulse outputs, osub_req, osub_enb, oready and oerr = 0.
  - orow, ocolumn, obank and odata = 0.
  - Refresh counter = 0; ref_pending = 0; wait counter = 0.
- Reset asserted mid-operation: osub_enb drops at the next edge and any in-flight client op is dropped with no odone.
- States:
  - S_INIT_REQ: osub_req[INIT] = 1 and osub_enb[INIT] = 1 for 1 cycle -> S_INIT_WAIT.
  - S_INIT_WAIT: hold osub_enb[INIT]. On isub_fin[INIT]: oready <= 1 and the refresh counter starts -> S_GAP.
  - S_IDLE: arbitrate with priority ref_pending > iwr_req > ird_req. On a win: load the sub index and -> S_GRANT. Otherwise stay.
  - S_GRANT (1 cycle): osub_req[idx] = 1 and osub_enb[idx] = 1.
    - For WR: owr_ack = 1; latch iwr_addr and iwr_data.
    - For RD: ord_ack = 1; latch ird_addr (odata unchanged).
    - For REF: clear ref_pending.
    - Clear the wait counter -> S_WAIT.
  - S_WAIT: hold osub_enb[idx] and increment the wait counter.
    - isub_fin[idx] = 1 -> odone = 1 (WR/RD only, not REF) and -> S_GAP.
    - Wait counter reaches TIMEOUT -> oerr <= 1, no odone, -> S_GAP.
    - Fin and timeout in the same cycle: fin wins.
  - S_GAP (1 cycle): osub_enb = 0 for bus turnaround -> S_IDLE.
- Client requests are ignored, and not acked, until oready = 1.
- Ack-to-done latency = sub-FSM duration + 1 cycle. Back-to-back grants are separated by at least the S_GAP and S_IDLE cycles.
- Refresh counter:
  - Free-runs after init. At REF_PERIOD-1 it wraps to 0 and sets ref_pending.
  - Expiry while ref_pending is already set: stays set (no stacking, no error).
  - Expiry in the same cycle that S_GRANT clears ref_pending for REF: set wins.
- Refresh is never preempted mid-operation; a pending refresh waits for the current op to reach S_IDLE.
- isub_fin from a non-granted index is ignored.
- osub_enb is one-hot or zero in every cycle. Latched outputs are held until the next grant.

Decomposition:
- Package sdram_sched_pkg:
  - state enum (S_INIT_REQ, S_INIT_WAIT, S_IDLE, S_GRANT, S_WAIT, S_GAP).
  - Sub index constants SUB_INIT=0, SUB_REF=1, SUB_WR=2, SUB_RD=3.
  - Address field slice constants.
- One sub-module, sdram_ref_timer: refresh counter plus ref_pending, with start/clear inputs.

Test Plan:
1. Init: release reset; assert isub_fin[0] 10 cycles later -> osub_req=4'b0001 pulse one cycle after reset release; oready rises one cycle after fin; first possible grant 2 cycles later.
2. Write: iwr_addr={2'd1,13'h0ABC,10'h055}, iwr_data=16'hBEEF -> owr_ack pulse; obank=1, orow=13'h0ABC, ocolumn=10'h055, odata=16'hBEEF; osub_enb=4'b0100 until isub_fin[2]; odone one cycle after fin.
3. Contention: iwr_req and ird_req raised in the same cycle with ref_pending=1 -> grant order REF, WR, RD; exactly one odone per client; no odone for REF.
4. Refresh timing: REF_PERIOD=20, no clients -> osub_req[1] pulses every 20 cycles ±(op length+2); two expiries during a long op yield a single refresh.
5. Timeout: TIMEOUT=8, never assert isub_fin[3] after a read grant -> oerr=1 after 8 wait cycles; no odone; return to S_IDLE; the next write completes normally.
6. Reset mid-write: drop ireset_n during S_WAIT -> next edge osub_enb=0, oready=0, oerr=0; init sequence restarts.
